// File: rtl/clic_target_pipe.sv
// clic_target_pipe: threshold-aware CLIC interrupt arbiter for one hart.
// A binary max-tree over (mode, prio) picks the winning pending & enabled
// source; optional register slices every PipeEvery levels bound timing.
// A small FSM offers the winner to the core over valid/ready, claims it,
// and can ask the core to withdraw an offer (kill) when a strictly higher
// interrupt appears.
// Optional feature: define CLIC_TARGET_SHV_EN to add shv_i / irq_shv_o;
// the shv bit rides along with the winner and never affects arbitration.
module clic_target_pipe #(
    parameter int unsigned N_SOURCE  = 256,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned ModeWidth = 2,
    parameter int unsigned PipeEvery = 0,
    localparam int unsigned SrcWidth = $clog2(N_SOURCE)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_SOURCE-1:0]                 ip_i,
    input  logic [N_SOURCE-1:0]                 ie_i,
    input  logic [N_SOURCE-1:0]                 le_i,
    input  logic [N_SOURCE-1:0][PrioWidth-1:0]  prio_i,
    input  logic [N_SOURCE-1:0][ModeWidth-1:0]  mode_i,
    input  logic [PrioWidth-1:0]                thresh_i,
    output logic [N_SOURCE-1:0]                 claim_o,
    output logic                                irq_valid_o,
    input  logic                                irq_ready_i,
    output logic [SrcWidth-1:0]                 irq_id_o,
    output logic [PrioWidth-1:0]                irq_max_o,
    output logic [ModeWidth-1:0]                irq_mode_o,
    output logic                                irq_kill_req_o,
    input  logic                                irq_kill_ack_i
`ifdef CLIC_TARGET_SHV_EN
   ,input  logic [N_SOURCE-1:0]                 shv_i,
    output logic                                irq_shv_o
`endif
);

    localparam int unsigned NumLevels = $clog2(N_SOURCE);
    localparam int unsigned NumLeaves = 1 << NumLevels;
    localparam int unsigned PipeDiv   = (PipeEvery == 0) ? 1 : PipeEvery;
    localparam int unsigned NumSlices = (PipeEvery == 0) ? 0 : NumLevels / PipeDiv;
    localparam int unsigned CntWidth  = (NumSlices > 1) ? $clog2(NumSlices + 1) : 1;

    typedef struct packed {
        logic                 valid;
        logic [ModeWidth-1:0] mode;
        logic [PrioWidth-1:0] prio;
        logic [SrcWidth-1:0]  id;
`ifdef CLIC_TARGET_SHV_EN
        logic                 shv;
`endif
    } node_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_CLAIM,
        S_SETTLE
    } state_e;

    // ------------------------------------------------------------------
    // Arbitration tree: level 0 holds the leaves, level NumLevels the root.
    // Left children always carry lower ids, so keeping C0 on a tie gives
    // the lower id.
    // ------------------------------------------------------------------
    for (genvar h = 0; h <= NumLevels; h++) begin : g_lvl
        localparam int unsigned Width = NumLeaves >> h;
        node_t lvl [Width];

        if (h == 0) begin : g_leaves
            for (genvar i = 0; i < Width; i++) begin : g_leaf
                if (i < N_SOURCE) begin : g_src
                    node_t leaf_d;
                    // Build the leaf record for one real source.
                    always_comb begin
                        // NOTE: default every field first so no path leaves a bit unassigned (no latch).
                        leaf_d       = '0;
                        leaf_d.valid = ip_i[i] & ie_i[i];
                        leaf_d.mode  = mode_i[i];
                        leaf_d.prio  = prio_i[i];
                        leaf_d.id    = SrcWidth'(i);
`ifdef CLIC_TARGET_SHV_EN
                        leaf_d.shv   = shv_i[i];
`endif
                    end
                    assign lvl[i] = leaf_d;
                end else begin : g_pad
                    assign lvl[i] = '0;
                end
            end
        end else begin : g_cmp
            localparam bit Sliced = (PipeEvery != 0) && ((h % PipeDiv) == 0);
            for (genvar j = 0; j < Width; j++) begin : g_node
                node_t c0, c1, node_d;
                assign c0 = g_lvl[h-1].lvl[2*j];
                assign c1 = g_lvl[h-1].lvl[2*j+1];

                // Pick the right child only when it strictly outranks the left one.
                always_comb begin
                    node_d = c0;
                    if (c1.valid && (!c0.valid || (c1.mode > c0.mode) ||
                                     ((c1.mode == c0.mode) && (c1.prio > c0.prio)))) begin
                        node_d = c1;
                    end
                end

                if (Sliced) begin : g_slice
                    node_t node_q;
                    // Register slice between tree levels.
                    always_ff @(posedge clk_i or negedge rst_ni) begin
                        if (!rst_ni) begin
                            // NOTE: slices are reset so every entry starts invalid; a stale valid would be offered.
                            node_q <= '0;
                        end else begin
                            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
                            node_q <= node_d;
                        end
                    end
                    assign lvl[j] = node_q;
                end else begin : g_wire
                    assign lvl[j] = node_d;
                end
            end
        end
    end

    node_t root;
    logic  root_valid;
    logic  root_higher;

    assign root       = g_lvl[NumLevels].lvl[0];
    assign root_valid = root.valid && (root.prio > thresh_i);

    // ------------------------------------------------------------------
    // Handshake FSM with registered outputs.
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  kill_q, kill_d;
    logic [SrcWidth-1:0]   id_q, id_d;
    logic [PrioWidth-1:0]  prio_q, prio_d;
    logic [ModeWidth-1:0]  mode_q, mode_d;
    logic [N_SOURCE-1:0]   claim_q, claim_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  leave_ack;
`ifdef CLIC_TARGET_SHV_EN
    logic                  shv_q, shv_d;
`endif

    // A new root only preempts when it strictly outranks the offered irq.
    assign root_higher = root_valid &&
                         ((root.mode > mode_q) || ((root.mode == mode_q) && (root.prio > prio_q)));

    // Next-state and next-output computation.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        kill_d    = kill_q;
        id_d      = id_q;
        prio_d    = prio_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        claim_d   = '0;
        leave_ack = 1'b0;
`ifdef CLIC_TARGET_SHV_EN
        shv_d     = shv_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (root_valid) begin
                    state_d = S_ACK;
                    valid_d = 1'b1;
                    kill_d  = 1'b0;
                    id_d    = root.id;
                    prio_d  = root.prio;
                    mode_d  = root.mode;
`ifdef CLIC_TARGET_SHV_EN
                    shv_d   = root.shv;
`endif
                end
            end
            S_ACK: begin
                if (!le_i[id_q] && !ip_i[id_q]) begin
                    // Level source deasserted before the core took it.
                    leave_ack = 1'b1;
                    state_d   = S_SETTLE;
                    cnt_d     = CntWidth'(NumSlices);
                end else if (valid_q && irq_ready_i) begin
                    // Acceptance wins over a simultaneous kill grant.
                    leave_ack      = 1'b1;
                    claim_d[id_q]  = 1'b1;
                    state_d        = S_CLAIM;
                end else if (kill_q && irq_kill_ack_i) begin
                    leave_ack = 1'b1;
                    state_d   = S_SETTLE;
                    cnt_d     = CntWidth'(NumSlices);
                end else if (root_higher) begin
                    kill_d = 1'b1;
                end
            end
            S_CLAIM: begin
                state_d = S_SETTLE;
                cnt_d   = CntWidth'(NumSlices);
            end
            S_SETTLE: begin
                // Wait out the tree latency so stale winners are flushed.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (leave_ack) begin
            valid_d = 1'b0;
            kill_d  = 1'b0;
            id_d    = '0;
            prio_d  = '0;
            mode_d  = '0;
`ifdef CLIC_TARGET_SHV_EN
            shv_d   = 1'b0;
`endif
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
            id_q    <= '0;
            prio_q  <= '0;
            mode_q  <= '0;
            claim_q <= '0;
            cnt_q   <= '0;
`ifdef CLIC_TARGET_SHV_EN
            shv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
            mode_q  <= mode_d;
            claim_q <= claim_d;
            cnt_q   <= cnt_d;
`ifdef CLIC_TARGET_SHV_EN
            shv_q   <= shv_d;
`endif
        end
    end

    assign irq_valid_o    = valid_q;
    assign irq_kill_req_o = kill_q;
    assign irq_id_o       = id_q;
    assign irq_max_o      = prio_q;
    assign irq_mode_o     = mode_q;
    assign claim_o        = claim_q;
`ifdef CLIC_TARGET_SHV_EN
    assign irq_shv_o      = shv_q;
`endif

endmodule

// File: tb/tb_clic_target_pipe.sv
// Self-checking bench for clic_target_pipe (N_SOURCE=8, PipeEvery=1, L=3).
// A transaction-level model (linear best-source search + L-deep delay line
// + offer/claim/settle rules) is compared to the DUT on every falling edge;
// directed scenarios add hand-computed literal checks.
module tb_clic_target_pipe;

    localparam int N   = 8;
    localparam int PW  = 8;
    localparam int MW  = 2;
    localparam int PE  = 1;
    localparam int NL  = $clog2(N);
    localparam int L   = NL / PE;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      ip, ie, le, shv;
    logic [N-1:0][PW-1:0] prio;
    logic [N-1:0][MW-1:0] mode;
    logic [PW-1:0]     thresh;
    logic [N-1:0]      claim_o;
    logic              irq_valid_o, irq_ready, irq_kill_req_o, irq_kill_ack;
    logic [NL-1:0]     irq_id_o;
    logic [PW-1:0]     irq_max_o;
    logic [MW-1:0]     irq_mode_o;
`ifdef CLIC_TARGET_SHV_EN
    logic              irq_shv_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clic_target_pipe #(
        .N_SOURCE (N),
        .PrioWidth(PW),
        .ModeWidth(MW),
        .PipeEvery(PE)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ip_i          (ip),
        .ie_i          (ie),
        .le_i          (le),
        .prio_i        (prio),
        .mode_i        (mode),
        .thresh_i      (thresh),
        .claim_o       (claim_o),
        .irq_valid_o   (irq_valid_o),
        .irq_ready_i   (irq_ready),
        .irq_id_o      (irq_id_o),
        .irq_max_o     (irq_max_o),
        .irq_mode_o    (irq_mode_o),
        .irq_kill_req_o(irq_kill_req_o),
        .irq_kill_ack_i(irq_kill_ack)
`ifdef CLIC_TARGET_SHV_EN
       ,.shv_i         (shv),
        .irq_shv_o     (irq_shv_o)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int id;
        int prio;
        int mode;
        bit shv;
    } cand_t;

    typedef enum {P_IDLE, P_OFFER, P_CLAIM, P_SETTLE} phase_e;

    phase_e   m_phase;
    cand_t    pipe [L];
    bit       e_valid, e_kill, e_shv;
    int       e_id, e_max, e_mode, settle_left;
    logic [N-1:0] e_claim;

    function automatic cand_t best();
        cand_t b;
        b.v = 0; b.id = 0; b.prio = 0; b.mode = 0; b.shv = 0;
        for (int i = 0; i < N; i++) begin
            if (ip[i] && ie[i]) begin
                if (!b.v || int'(mode[i]) > b.mode ||
                    (int'(mode[i]) == b.mode && int'(prio[i]) > b.prio)) begin
                    b.v = 1; b.id = i; b.prio = int'(prio[i]);
                    b.mode = int'(mode[i]); b.shv = shv[i];
                end
            end
        end
        return b;
    endfunction

    function automatic bit offerable(input cand_t c);
        return c.v && (c.prio > int'(thresh));
    endfunction

    function automatic bit outranks(input cand_t c);
        return offerable(c) && (c.mode > e_mode || (c.mode == e_mode && c.prio > e_max));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE;
            e_valid <= 0; e_kill <= 0; e_shv <= 0;
            e_id <= 0; e_max <= 0; e_mode <= 0; settle_left <= 0;
            e_claim <= '0;
            for (int j = 0; j < L; j++) pipe[j] <= '{default: 0};
        end else begin
            pipe[0] <= best();
            for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
            e_claim <= '0;
            case (m_phase)
                P_IDLE: if (offerable(pipe[L-1])) begin
                    m_phase <= P_OFFER;
                    e_valid <= 1; e_kill <= 0;
                    e_id <= pipe[L-1].id; e_max <= pipe[L-1].prio;
                    e_mode <= pipe[L-1].mode; e_shv <= pipe[L-1].shv;
                end
                P_OFFER: begin
                    if ((!le[e_id] && !ip[e_id]) || irq_ready || (e_kill && irq_kill_ack)) begin
                        e_valid <= 0; e_kill <= 0; e_shv <= 0;
                        e_id <= 0; e_max <= 0; e_mode <= 0;
                        if (!(!le[e_id] && !ip[e_id]) && irq_ready) begin
                            m_phase <= P_CLAIM;
                            e_claim <= N'(1) << e_id;
                        end else begin
                            m_phase <= P_SETTLE;
                            settle_left <= L;
                        end
                    end else if (outranks(pipe[L-1])) begin
                        e_kill <= 1;
                    end
                end
                P_CLAIM: begin
                    m_phase <= P_SETTLE;
                    settle_left <= L;
                end
                P_SETTLE: begin
                    if (settle_left == 0) m_phase <= P_IDLE;
                    else settle_left <= settle_left - 1;
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check("valid", irq_valid_o, e_valid);
        check("id", irq_id_o, e_id);
        check("max", irq_max_o, e_max);
        check("mode", irq_mode_o, e_mode);
        check("kill_req", irq_kill_req_o, e_kill);
        check("claim", claim_o, e_claim);
`ifdef CLIC_TARGET_SHV_EN
        check("shv", irq_shv_o, e_shv);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic clear_inputs();
        ip = '0; ie = '0; le = '1; shv = '0;
        prio = '0; mode = '0; thresh = '0;
        irq_ready = 0; irq_kill_ack = 0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!irq_valid_o && n < budget) begin
            step(1);
            n++;
        end
        check(name, irq_valid_o, 1'b1);
    endtask

    task automatic wait_kill(input string name, input int budget);
        int n = 0;
        while (!irq_kill_req_o && n < budget) begin
            step(1);
            n++;
        end
        check(name, irq_kill_req_o, 1'b1);
    endtask

    task automatic accept(input string name, input logic [N-1:0] exp_claim);
        irq_ready = 1;
        step(1);
        check(name, claim_o, exp_claim);
        irq_ready = 0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 0;
        clear_inputs();
        #2;
        check("rst_valid", irq_valid_o, 0);
        check("rst_id", irq_id_o, 0);
        check("rst_kill", irq_kill_req_o, 0);
        check("rst_claim", claim_o, 0);
        step(2);
        rst_n = 1;
        step(2);

        // 1: single source, latency L+1, claim, no re-offer
        prio[2] = 8'd5; mode[2] = 2'd3; ip = 8'h04; ie = 8'h04;
        step(3);
        check("t1_not_yet", irq_valid_o, 0);
        step(1);
        check("t1_valid", irq_valid_o, 1);
        check("t1_id", irq_id_o, 2);
        check("t1_max", irq_max_o, 5);
        check("t1_mode", irq_mode_o, 3);
        accept("t1_claim", 8'h04);
        check("t1_valid_drop", irq_valid_o, 0);
        ip = '0;
        step(1);
        check("t1_claim_once", claim_o, 0);
        step(10);
        check("t1_no_reoffer", irq_valid_o, 0);
        clear_inputs(); step(6);

        // 2: equal priority tie -> lower id
        prio[1] = 8'd7; prio[2] = 8'd7; ip = 8'h06; ie = 8'h06;
        wait_valid("t2_wait", 12);
        check("t2_id", irq_id_o, 1);
        check("t2_max", irq_max_o, 7);
        accept("t2_claim", 8'h02);
        clear_inputs(); step(8);

        // 2b: higher mode beats higher priority
        prio[0] = 8'd200; mode[0] = 2'd1; prio[7] = 8'd1; mode[7] = 2'd3;
        ip = 8'h81; ie = 8'h81;
        wait_valid("t2b_wait", 12);
        check("t2b_id", irq_id_o, 7);
        check("t2b_mode", irq_mode_o, 3);
        accept("t2b_claim", 8'h80);
        clear_inputs(); step(8);

        // 3: threshold gating; later threshold change does not retract
        thresh = 8'd8; prio[2] = 8'd8; ip = 8'h04; ie = 8'h04;
        step(8);
        check("t3_blocked", irq_valid_o, 0);
        thresh = 8'd7;
        wait_valid("t3_wait", 12);
        check("t3_id", irq_id_o, 2);
        thresh = 8'd255;
        step(3);
        check("t3_held", irq_valid_o, 1);
        accept("t3_claim", 8'h04);
        clear_inputs(); step(8);

        // 4: preemption by kill
        prio[2] = 8'd5; prio[6] = 8'd9; ip = 8'h04; ie = 8'h04;
        wait_valid("t4_wait", 12);
        ip = 8'h44; ie = 8'h44;
        step(3);
        check("t4_kill_early", irq_kill_req_o, 0);
        step(1);
        check("t4_kill", irq_kill_req_o, 1);
        check("t4_id_held", irq_id_o, 2);
        irq_kill_ack = 1;
        step(1);
        irq_kill_ack = 0;
        check("t4_valid_drop", irq_valid_o, 0);
        check("t4_kill_drop", irq_kill_req_o, 0);
        check("t4_no_claim", claim_o, 0);
        wait_valid("t4_wait6", 20);
        check("t4_id6", irq_id_o, 6);
        check("t4_max6", irq_max_o, 9);
        accept("t4_claim6", 8'h40);
        ip = 8'h04;
        wait_valid("t4_wait2", 20);
        check("t4_id2", irq_id_o, 2);
        accept("t4_claim2", 8'h04);
        clear_inputs(); step(8);

        // 4b: ready and kill_ack together -> ready wins
        prio[2] = 8'd5; prio[6] = 8'd9; ip = 8'h04; ie = 8'h04;
        wait_valid("t4b_wait", 12);
        ip = 8'h44; ie = 8'h44;
        wait_kill("t4b_kill", 12);
        irq_ready = 1; irq_kill_ack = 1;
        step(1);
        irq_ready = 0; irq_kill_ack = 0;
        check("t4b_claim", claim_o, 8'h04);
        check("t4b_kill_drop", irq_kill_req_o, 0);
        ip = 8'h40;
        wait_valid("t4b_wait6", 20);
        check("t4b_id6", irq_id_o, 6);
        accept("t4b_claim6", 8'h40);
        clear_inputs(); step(8);

        // 4c: equal-ranked newcomer never kills
        prio[5] = 8'd5; ip = 8'h20; ie = 8'h20;
        wait_valid("t4c_wait", 12);
        prio[2] = 8'd5; ip = 8'h24; ie = 8'h24;
        step(6);
        check("t4c_no_kill", irq_kill_req_o, 0);
        check("t4c_id", irq_id_o, 5);
        accept("t4c_claim", 8'h20);
        clear_inputs(); step(8);

        // 5: level source withdrawn before ready
        le[3] = 1'b0; prio[3] = 8'd4; ip = 8'h08; ie = 8'h08;
        wait_valid("t5_wait", 12);
        check("t5_id", irq_id_o, 3);
        ip = 8'h00;
        step(1);
        check("t5_valid_drop", irq_valid_o, 0);
        check("t5_no_claim", claim_o, 0);
        step(3);
        check("t5_no_claim_later", claim_o, 0);
        clear_inputs(); step(8);

        // 6: async reset mid-handshake
        prio[5] = 8'd6; shv[5] = 1'b1; ip = 8'h20; ie = 8'h20;
        wait_valid("t6_wait", 12);
        check("t6_id", irq_id_o, 5);
`ifdef CLIC_TARGET_SHV_EN
        check("t6_shv", irq_shv_o, 1);
`endif
        #1;
        rst_n = 0;
        #1;
        check("t6_rst_valid", irq_valid_o, 0);
        check("t6_rst_id", irq_id_o, 0);
        check("t6_rst_max", irq_max_o, 0);
        check("t6_rst_claim", claim_o, 0);
`ifdef CLIC_TARGET_SHV_EN
        check("t6_rst_shv", irq_shv_o, 0);
`endif
        step(2);
        rst_n = 1;
        step(3);
        check("t6_flushed", irq_valid_o, 0);
        wait_valid("t6_wait2", 12);
        check("t6_id2", irq_id_o, 5);
        accept("t6_claim", 8'h20);
        clear_inputs(); step(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
